// File: rtl/cache_pkg.sv
// Shared types and constants for the cache set read/refill controller.
package cache_pkg;

  localparam int TAG_W = 24;
  localparam int WAYS  = 8;
  localparam int WAY_W = 3;

  // Controller states: accept, compare, wait for refill, write back, respond.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    FILL   = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Decode a way index into a one-hot way select.
  function automatic logic [WAYS-1:0] one_hot(input logic [WAY_W-1:0] way);
    logic [WAYS-1:0] sel;
    sel      = '0;
    sel[way] = 1'b1;
    return sel;
  endfunction

endpackage : cache_pkg

// File: rtl/cache_tag_match.sv
// Combinational tag compare for one 8-way set: valid-gated comparators,
// lowest-index hit encoder and lowest-index invalid-way finder.
module cache_tag_match
  import cache_pkg::*;
(
  input  logic [TAG_W-1:0] tags [WAYS],
  input  logic [WAYS-1:0]  viv,
  input  logic [TAG_W-1:0] tag,
  output logic             hit,
  output logic [WAY_W-1:0] way,
  output logic             any_invalid,
  output logic [WAY_W-1:0] inv_way
);

  logic [WAYS-1:0] match;

  // A way matches only if it holds a valid line with the same tag.
  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      match[i] = viv[i] && (tags[i] == tag);
    end
  end

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    hit = |match;
    way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (match[i]) way = WAY_W'(i);
    end
  end

  // Lowest-index empty way is the preferred victim on a miss.
  always_comb begin
    any_invalid = ~&viv;
    inv_way     = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!viv[i]) inv_way = WAY_W'(i);
    end
  end

endmodule : cache_tag_match

// File: rtl/cache_lookup.sv
// Read-side controller and refill master for one 8-way cache set.
// All outputs are registered and decoded from the next state, so they
// line up with the current state and are all zero while in reset.
module cache_lookup
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [TAG_W-1:0] tag0,
  input  logic [TAG_W-1:0] tag1,
  input  logic [TAG_W-1:0] tag2,
  input  logic [TAG_W-1:0] tag3,
  input  logic [TAG_W-1:0] tag4,
  input  logic [TAG_W-1:0] tag5,
  input  logic [TAG_W-1:0] tag6,
  input  logic [TAG_W-1:0] tag7,
  input  logic [WAYS-1:0]  out_viv,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [WAY_W-1:0] resp_way,
  output logic             fill_req,
  output logic [TAG_W-1:0] fill_tag,
  output logic [WAY_W-1:0] fill_way,
  input  logic             fill_done,
  output logic             regWrite,
  output logic [WAYS-1:0]  decOut1b_viv,
  output logic [WAYS-1:0]  inp_viv,
  output logic [TAG_W-1:0] wr_tag
);

  state_t state, state_next;

  // Request context held across the transaction.
  logic [TAG_W-1:0] cur_tag, cur_tag_next;
  logic [WAY_W-1:0] victim, victim_next;
  logic             from_rr, from_rr_next;
  logic             hit_r, hit_next;
  logic [WAY_W-1:0] way_r, way_next;
  logic [WAY_W-1:0] rr_ptr, rr_next;

  // Next values for the registered outputs.
  logic             req_ready_n;
  logic             resp_valid_n;
  logic             resp_hit_n;
  logic [WAY_W-1:0] resp_way_n;
  logic             fill_req_n;
  logic [TAG_W-1:0] fill_tag_n;
  logic [WAY_W-1:0] fill_way_n;
  logic             reg_write_n;
  logic [WAYS-1:0]  dec_n;
  logic [TAG_W-1:0] wr_tag_n;

  // Tag compare results.
  logic [TAG_W-1:0] tags [WAYS];
  logic             match_hit;
  logic [WAY_W-1:0] match_way;
  logic             any_invalid;
  logic [WAY_W-1:0] inv_way;

  assign tags = '{tag0, tag1, tag2, tag3, tag4, tag5, tag6, tag7};

  cache_tag_match u_match (
    .tags        (tags),
    .viv         (out_viv),
    .tag         (cur_tag),
    .hit         (match_hit),
    .way         (match_way),
    .any_invalid (any_invalid),
    .inv_way     (inv_way)
  );

  // Next-state, context update and output decode for the controller.
  always_comb begin
    state_next   = state;
    cur_tag_next = cur_tag;
    victim_next  = victim;
    from_rr_next = from_rr;
    hit_next     = hit_r;
    way_next     = way_r;
    rr_next      = rr_ptr;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          cur_tag_next = req_tag;
          state_next   = LOOKUP;
        end
      end
      LOOKUP: begin
        if (match_hit) begin
          hit_next   = 1'b1;
          way_next   = match_way;
          state_next = RESP;
        end else begin
          // Fill an empty way if there is one; otherwise evict round-robin.
          victim_next  = any_invalid ? inv_way : rr_ptr;
          from_rr_next = !any_invalid;
          state_next   = FILL;
        end
      end
      FILL: begin
        if (fill_done) state_next = WRITE;
      end
      WRITE: begin
        // Only a round-robin eviction advances the pointer; 7 wraps to 0.
        if (from_rr) rr_next = rr_ptr + WAY_W'(1);
        hit_next   = 1'b0;
        way_next   = victim;
        state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are decoded from the state being entered so they register
    // alongside it; fields outside their own state are forced to zero.
    req_ready_n  = (state_next == IDLE);
    fill_req_n   = (state_next == FILL);
    fill_tag_n   = fill_req_n ? cur_tag_next : '0;
    fill_way_n   = fill_req_n ? victim_next : '0;
    reg_write_n  = (state_next == WRITE);
    dec_n        = reg_write_n ? one_hot(victim_next) : '0;
    wr_tag_n     = reg_write_n ? cur_tag_next : '0;
    resp_valid_n = (state_next == RESP);
    resp_hit_n   = resp_valid_n ? hit_next : 1'b0;
    resp_way_n   = resp_valid_n ? way_next : '0;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Transaction context and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_tag <= '0;
      victim  <= '0;
      from_rr <= 1'b0;
      hit_r   <= 1'b0;
      way_r   <= '0;
      rr_ptr  <= '0;
    end else begin
      cur_tag <= cur_tag_next;
      victim  <= victim_next;
      from_rr <= from_rr_next;
      hit_r   <= hit_next;
      way_r   <= way_next;
      rr_ptr  <= rr_next;
    end
  end

  // Registered outputs; reset clears all of them, aborting any fill or write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_way     <= '0;
      fill_req     <= 1'b0;
      fill_tag     <= '0;
      fill_way     <= '0;
      regWrite     <= 1'b0;
      decOut1b_viv <= '0;
      inp_viv      <= '0;
      wr_tag       <= '0;
    end else begin
      req_ready    <= req_ready_n;
      resp_valid   <= resp_valid_n;
      resp_hit     <= resp_hit_n;
      resp_way     <= resp_way_n;
      fill_req     <= fill_req_n;
      fill_tag     <= fill_tag_n;
      fill_way     <= fill_way_n;
      regWrite     <= reg_write_n;
      decOut1b_viv <= dec_n;
      // The written valid bits mirror the way select: the victim becomes valid.
      inp_viv      <= dec_n;
      wr_tag       <= wr_tag_n;
    end
  end

endmodule : cache_lookup

// File: tb/tb_cache_lookup.sv
// Directed self-checking bench for cache_lookup. The bench owns a model of
// the set storage and round-robin pointer, and queues expected responses.
module tb_cache_lookup;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_tag;
  logic [23:0] m_tag [8];
  logic [7:0]  m_viv;
  logic [2:0]  m_rr;
  logic        resp_valid;
  logic        resp_hit;
  logic [2:0]  resp_way;
  logic        fill_req;
  logic [23:0] fill_tag;
  logic [2:0]  fill_way;
  logic        fill_done;
  logic        regWrite;
  logic [7:0]  decOut1b_viv;
  logic [7:0]  inp_viv;
  logic [23:0] wr_tag;

  typedef struct packed {
    logic       hit;
    logic [2:0] way;
  } resp_t;

  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  cache_lookup dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_tag      (req_tag),
    .tag0         (m_tag[0]),
    .tag1         (m_tag[1]),
    .tag2         (m_tag[2]),
    .tag3         (m_tag[3]),
    .tag4         (m_tag[4]),
    .tag5         (m_tag[5]),
    .tag6         (m_tag[6]),
    .tag7         (m_tag[7]),
    .out_viv      (m_viv),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_way     (resp_way),
    .fill_req     (fill_req),
    .fill_tag     (fill_tag),
    .fill_way     (fill_way),
    .fill_done    (fill_done),
    .regWrite     (regWrite),
    .decOut1b_viv (decOut1b_viv),
    .inp_viv      (inp_viv),
    .wr_tag       (wr_tag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction, starting and ending on a falling edge in IDLE.
  // delay = extra FILL cycles before fill_done is raised.
  task automatic run_req(input logic [23:0] tag, input int delay);
    logic       exp_hit;
    logic [2:0] exp_way;
    logic       use_rr;
    resp_t      e;
    exp_hit = 1'b0;
    exp_way = 3'd0;
    use_rr  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (m_viv[i] && m_tag[i] == tag) begin
        exp_hit = 1'b1;
        exp_way = 3'(i);
      end
    end
    if (!exp_hit) begin
      if (m_viv == 8'hFF) begin
        exp_way = m_rr;
        use_rr  = 1'b1;
      end else begin
        for (int i = 7; i >= 0; i--) if (!m_viv[i]) exp_way = 3'(i);
      end
    end
    exp_q.push_back('{hit: exp_hit, way: exp_way});

    check("ready_in_idle", req_ready, 1);
    req_valid = 1'b1;
    req_tag   = tag;
    @(negedge clk);
    req_valid = 1'b0;
    check("ready_low_lookup", req_ready, 0);
    check("no_resp_lookup", resp_valid, 0);
    check("no_fill_lookup", fill_req, 0);
    @(negedge clk);
    if (!exp_hit) begin
      check("fill_req", fill_req, 1);
      check("fill_way", fill_way, exp_way);
      check("fill_tag", fill_tag, tag);
      check("no_resp_fill", resp_valid, 0);
      for (int k = 0; k < delay; k++) begin
        @(negedge clk);
        check("fill_held", fill_req, 1);
        check("no_write_fill", regWrite, 0);
      end
      fill_done = 1'b1;
      @(negedge clk);
      fill_done = 1'b0;
      check("regwrite", regWrite, 1);
      check("dec_onehot", decOut1b_viv, 8'h01 << exp_way);
      check("inp_viv", inp_viv, 8'h01 << exp_way);
      check("wr_tag", wr_tag, tag);
      check("fill_dropped", fill_req, 0);
      // Storage model takes the write, as cache_set would.
      m_tag[exp_way] = tag;
      m_viv[exp_way] = 1'b1;
      if (use_rr) m_rr = m_rr + 3'd1;
      @(negedge clk);
    end
    check("resp_valid", resp_valid, 1);
    check("no_fill_resp", fill_req, 0);
    check("no_write_resp", regWrite, 0);
    e = exp_q.pop_front();
    check("resp_hit", resp_hit, e.hit);
    check("resp_way", resp_way, e.way);
    @(negedge clk);
    check("resp_one_cycle", resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_tag   = '0;
    fill_done = 1'b0;
    m_viv     = 8'h00;
    m_rr      = 3'd0;
    for (int i = 0; i < 8; i++) m_tag[i] = 24'h100000 + 24'(i);

    // Reset state: every output low, including req_ready.
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_fill_req", fill_req, 0);
    check("rst_regwrite", regWrite, 0);
    check("rst_dec", decOut1b_viv, 0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1);

    // Hit, lowest index wins between ways 3 and 5.
    m_viv    = 8'hFF;
    m_tag[3] = 24'hABCDEF;
    m_tag[5] = 24'hABCDEF;
    run_req(24'hABCDEF, 0);

    // Stray fill_done in IDLE, then held through a hit's LOOKUP.
    fill_done = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("stray_idle_ready", req_ready, 1);
      check("stray_idle_write", regWrite, 0);
      check("stray_idle_fill", fill_req, 0);
    end
    run_req(24'h100006, 0);
    fill_done = 1'b0;

    // Cold miss into way 3, then the written line hits.
    m_viv = 8'b0000_0111;
    run_req(24'h123456, 3);
    run_req(24'h123456, 0);

    // Matching tag in an invalid way must not hit.
    m_viv    = 8'b1111_1011;
    m_tag[2] = 24'hBEEF02;
    run_req(24'hBEEF02, 1);

    // Round-robin: nine misses on a full set evict 0..7 then 0.
    m_viv = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      check("rr_model", m_rr, k % 8);
      run_req(24'h200000 + 24'(k), k % 3);
    end

    // Reset during FILL aborts the refill and clears the pointer.
    check("abort_ready", req_ready, 1);
    req_valid = 1'b1;
    req_tag   = 24'h777001;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_fill_req", fill_req, 1);
    check("abort_fill_way", fill_way, m_rr);
    reset = 1'b0;
    @(negedge clk);
    check("abort_fill_drop", fill_req, 0);
    check("abort_no_write", regWrite, 0);
    check("abort_no_resp", resp_valid, 0);
    check("abort_ready_low", req_ready, 0);
    reset = 1'b1;
    m_rr  = 3'd0;
    @(negedge clk);
    check("abort_ready_back", req_ready, 1);
    check("abort_no_write2", regWrite, 0);
    check("abort_no_resp2", resp_valid, 0);
    run_req(24'h777002, 2);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cache_lookup

// File: doc/cache_lookup.md
# cache_lookup

Read-side controller for one 8-way cache set. It accepts a tag lookup request and compares it against the eight stored tags and valid bits of the set. A hit returns the matching way; a miss picks a victim way, runs a fill handshake and then writes the new tag and valid bit back into the set through its write port. It is the reader and refill master paired with `cache_set`, which remains a pure storage block.

## Interface
- WAYS, 8, number of ways (fixed at 8 in this revision)
- TAG_W, 24, tag width
- clk  in  1  system clock, all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  lookup request present
- req_ready  out  1  controller can accept a request
- req_tag  in  24  tag to look up
- tag0..tag7  in  24 each  stored tags read from the set
- out_viv  in  8  stored valid bits read from the set, bit i = way i
- resp_valid  out  1  one-cycle response strobe
- resp_hit  out  1  1 = hit, 0 = miss that has completed its fill
- resp_way  out  3  way that hit or way that was filled
- fill_req  out  1  request for line fill from the next level
- fill_tag  out  24  tag being filled
- fill_way  out  3  way being filled
- fill_done  in  1  next level has completed the fill
- regWrite  out  1  write strobe to the set
- decOut1b_viv  out  8  one-hot way select for the write
- inp_viv  out  8  valid bit data to write, bit i = way i
- wr_tag  out  24  tag data to write

## Operation
- FSM states: IDLE, LOOKUP, FILL, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid=1, latch req_tag into cur_tag and go to LOOKUP.
- LOOKUP:
  - Way i matches when out_viv[i]=1 and tag_i==cur_tag.
  - Any match: set hit=1 and way = lowest matching index, then go to RESP.
  - No match: select a victim, then go to FILL.
  - Victim is the lowest-index way with out_viv[i]=0. If all 8 ways are valid, the victim is rr_ptr and a flag from_rr is set.
- FILL:
  - fill_req=1, with fill_tag=cur_tag and fill_way=victim, held stable.
  - Stay in FILL until fill_done=1 is sampled, then go to WRITE.
  - fill_done is ignored in every other state.
- WRITE, exactly one cycle:
  - regWrite=1.
  - decOut1b_viv = one-hot(victim).
  - inp_viv = one-hot(victim), so the selected way is written valid.
  - wr_tag = cur_tag.
  - If from_rr is set, rr_ptr = rr_ptr+1, modulo 8 (7 wraps to 0).
  - Then go to RESP with hit=0 and way=victim.
- RESP:
  - resp_valid=1 for one cycle, with resp_hit and resp_way valid.
  - Return to IDLE. There is no backpressure on the response.
- Outside WRITE: regWrite=0 and decOut1b_viv=0. No spurious writes occur.
- rr_ptr changes only in WRITE, and only when from_rr is set.

## Timing
- Reset (reset=0 sampled at an edge):
  - state=IDLE, rr_ptr=0, cur_tag=0.
  - All outputs are 0, including req_ready.
  - req_ready=1 from the first cycle with reset=1.
- Reset mid-operation aborts immediately:
  - No WRITE and no resp_valid.
  - fill_req drops on the next edge.
- Hit latency: request accepted at edge N, LOOKUP in cycle N+1, resp_valid in cycle N+2. Three-cycle occupancy.
- Miss latency: fill_req high from cycle N+2. If fill_done is sampled at edge K:
  - regWrite is high in cycle K+1.
  - resp_valid is high in cycle K+2.
- req_ready=0 in every state except IDLE. Back-to-back hits complete one every 3 cycles.
- The tag and valid inputs are sampled only in LOOKUP. A write made in WRITE is visible to the next request's LOOKUP.

## Structure
- Package `cache_pkg`:
  - TAG_W, WAYS, WAY_W=3.
  - FSM state enum.
  - one_hot helper function.
- One sub-module, `cache_tag_match`. It is combinational and holds:
  - the 8 comparators gated by the valid bits;
  - the priority encoder that outputs hit and way;
  - the first-invalid finder that outputs any_invalid and inv_way.
- The FSM, rr_ptr and the output registers stay in `cache_lookup`.

## Test plan
- Hit, lowest index wins:
  - Stimulus: out_viv=8'hFF, tag3=tag5=24'hABCDEF, request 24'hABCDEF.
  - Response: resp_valid at N+2, resp_hit=1, resp_way=3, fill_req never asserted.
- Cold miss:
  - Stimulus: out_viv=8'b0000_0111, request 24'h123456, fill_done 4 cycles after fill_req.
  - Response: fill_way=3. regWrite for 1 cycle with decOut1b_viv=8'h08, inp_viv=8'h08, wr_tag=24'h123456. Then resp_hit=0, resp_way=3.
- Round-robin wrap:
  - Stimulus: all ways valid, 9 consecutive misses.
  - Response: victims 0,1,…,7,0 in that order.
- Valid gating:
  - Stimulus: tag2 matches the request but out_viv[2]=0.
  - Response: miss handled, victim=2.
- Reset abort:
  - Stimulus: reset=0 during FILL.
  - Response: fill_req=0 next cycle, no regWrite, no resp_valid, req_ready=1 after release, rr_ptr=0.
- Stray fill_done:
  - Stimulus: fill_done=1 while in IDLE or LOOKUP on a hit.
  - Response: no state change, no regWrite.
